// File: rtl/perf_monitor_pkg.sv
// Shared types and widths for the perf_monitor slice (run/halt FSM encodings, bus widths).
package perf_monitor_pkg;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned RD_SEL_W   = 4;
  localparam int unsigned MAX_EVENTS = 15;

  typedef enum logic [1:0] {
    PM_IDLE = 2'b00,
    PM_RUN  = 2'b01,
    PM_HALT = 2'b10
  } pm_state_e;

  // Number of counters behind the readout mux: cycle counter plus one per event.
  function automatic int unsigned num_counters(input int unsigned num_events);
    return num_events + 1;
  endfunction

endpackage

// File: rtl/perf_monitor_if.sv
// Control, event, dmem-snoop and readout signals of perf_monitor, with core-side (master)
// and monitor-side (slave) views.
interface perf_monitor_if
  import perf_monitor_pkg::*;
#(
  parameter int unsigned NUM_EVENTS = 2,
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned ADDR_W     = DATA_W
);

  logic                  start;
  logic                  clear;
  logic [NUM_EVENTS-1:0] event_i;
  logic [ADDR_W-1:0]     daddr;
  logic [DATA_W-1:0]     dwdata;
  logic                  we;
  logic [RD_SEL_W-1:0]   rd_sel;
  logic [CNT_W-1:0]      rd_data;
  logic                  running;
  logic                  halted;
  logic [DATA_W-1:0]     halt_code;

  modport master (
    output start, clear, event_i, daddr, dwdata, we, rd_sel,
    input  rd_data, running, halted, halt_code
  );

  modport slave (
    input  start, clear, event_i, daddr, dwdata, we, rd_sel,
    output rd_data, running, halted, halt_code
  );

endinterface

// File: rtl/perf_counter.sv
// Single clearable event counter. Wraps modulo 2^CNT_W by default; with PERFMON_SAT_EN
// defined it sticks at all-ones until cleared or reset.
module perf_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] q
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
`ifdef PERFMON_SAT_EN
      if (cnt_q != {CNT_W{1'b1}}) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
`else
      cnt_d = cnt_q + CNT_W'(1);
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q = cnt_q;

endmodule

// File: rtl/perf_monitor.sv
// Performance monitor and halt detector beside the MIPS core's dmem bus.
// Counter overflow behaviour selected by PERFMON_SAT_EN (saturate) vs default (wrap).
module perf_monitor
  import perf_monitor_pkg::*;
#(
  parameter int unsigned       NUM_EVENTS = 2,
  parameter int unsigned       CNT_W      = 32,
  parameter int unsigned       ADDR_W     = DATA_W,
  parameter logic [ADDR_W-1:0] HALT_ADDR  = ADDR_W'(32'h7fff)
) (
  input logic           clk,
  input logic           rst_n,
  perf_monitor_if.slave bus
);

  localparam int unsigned NUM_CNT = num_counters(NUM_EVENTS);

  pm_state_e         state_q;
  pm_state_e         state_d;
  logic              running_q;
  logic              running_d;
  logic              halted_q;
  logic              halted_d;
  logic [CNT_W-1:0]  rd_data_q;
  logic [CNT_W-1:0]  rd_data_d;
  logic [DATA_W-1:0] halt_code_q;
  logic [DATA_W-1:0] halt_code_d;

  logic              halt_store_c;
  logic [NUM_CNT-1:0] inc_c;
  logic [CNT_W-1:0]  cnt_q [NUM_CNT];

  always_comb begin
    halt_store_c = (state_q == PM_RUN) && bus.we && (bus.daddr == HALT_ADDR);
  end

  // Next state: clear beats a halt store, which beats start.
  always_comb begin
    state_d = state_q;
    if (bus.clear) begin
      state_d = PM_IDLE;
    end else begin
      case (state_q)
        PM_IDLE: if (bus.start)   state_d = PM_RUN;
        PM_RUN:  if (halt_store_c) state_d = PM_HALT;
        PM_HALT: state_d = PM_HALT;
        default: state_d = PM_IDLE;
      endcase
    end
    running_d = (state_d == PM_RUN);
    halted_d  = (state_d == PM_HALT);
  end

  // Counter 0 counts run cycles; counter k counts event_i[k-1] while running.
  always_comb begin
    inc_c = '0;
    if (state_q == PM_RUN) begin
      inc_c[0]         = 1'b1;
      inc_c[NUM_CNT-1:1] = bus.event_i;
    end
  end

  for (genvar g = 0; g < NUM_CNT; g++) begin : g_cnt
    perf_counter #(
      .CNT_W (CNT_W)
    ) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (bus.clear),
      .inc   (inc_c[g]),
      .q     (cnt_q[g])
    );
  end

  // Readout samples the counter registers, so a same-cycle increment is not yet visible.
  always_comb begin
    rd_data_d = '0;
    if (!bus.clear) begin
      for (int unsigned k = 0; k < NUM_CNT; k++) begin
        if (bus.rd_sel == RD_SEL_W'(k)) begin
          rd_data_d = cnt_q[k];
        end
      end
    end
  end

  always_comb begin
    halt_code_d = halt_code_q;
    if (bus.clear) begin
      halt_code_d = '0;
    end else if (halt_store_c) begin
      halt_code_d = bus.dwdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= PM_IDLE;
      running_q   <= 1'b0;
      halted_q    <= 1'b0;
      rd_data_q   <= '0;
      halt_code_q <= '0;
    end else begin
      state_q     <= state_d;
      running_q   <= running_d;
      halted_q    <= halted_d;
      rd_data_q   <= rd_data_d;
      halt_code_q <= halt_code_d;
    end
  end

  assign bus.running   = running_q;
  assign bus.halted    = halted_q;
  assign bus.rd_data   = rd_data_q;
  assign bus.halt_code = halt_code_q;

endmodule
